// File: rtl/sb_pkg.sv
// sb_pkg: shared control-bit indices, entry type and pointer sizing for the store buffer
package sb_pkg;
    localparam int CTRL_RD = 1;
    localparam int CTRL_WR = 2;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
    function automatic int ptrWidth(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/sb_match.sv
// sb_match: DEPTH-way address compare with youngest-first priority select
module sb_match import sb_pkg::*; #(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int DEPTH = 4,
    localparam int PW = ptrWidth(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] entAddr [DEPTH],
    input  logic [DATA_W-1:0] entData [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PW-1:0]     tail,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic [PW-1:0] idx;
    // walk oldest to youngest so the youngest match is the last to assign
    always_comb begin
        hit = 1'b0;
        data = '0;
        idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail - PW'(k + 1);
            if (valid[idx] && entAddr[idx] == addr) begin
                hit = 1'b1;
                data = entData[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between CPU and data memory with load forwarding and coalescing
module store_buffer import sb_pkg::*; #(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic              InputClk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_ctrl,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              sb_empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic              mem_ready
);
    localparam int PW = ptrWidth(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_W-1:0] entAddr [DEPTH];
    logic [DATA_W-1:0] entData [DEPTH];
    logic [PW-1:0] head, tail, youngest;
    logic [CW-1:0] count;
    logic [DEPTH-1:0] valid;
    logic [DATA_W-1:0] hitData;
    logic wr, rd, hit, loadMiss, drain, coalesce, enq, full, nonEmpty;
    assign wr = cpu_ctrl[CTRL_WR];
    assign rd = cpu_ctrl[CTRL_RD] & ~wr;
    assign youngest = tail - PW'(1);
    assign nonEmpty = count != '0;
    assign full = count == CW'(DEPTH);
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - head} < count;
    end
    sb_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) uMatch (
        .addr(cpu_addr),
        .entAddr(entAddr),
        .entData(entData),
        .valid(valid),
        .tail(tail),
        .hit(hit),
        .data(hitData)
    );
    assign loadMiss = rd & ~hit;
    assign drain = nonEmpty & mem_ready & ~loadMiss;
    // a lone entry retiring this cycle cannot absorb a coalesce; the store becomes a new entry
    assign coalesce = wr & nonEmpty & (entAddr[youngest] == cpu_addr) & ~(count == CW'(1) & drain);
    assign enq = wr & ~coalesce & ~full;
    assign stall = wr & ~coalesce & full;
    assign sb_empty = ~nonEmpty;
    assign mem_read_en = loadMiss;
    assign mem_write_en = drain;
    assign mem_addr = loadMiss ? cpu_addr : drain ? entAddr[head] : '0;
    assign mem_wdata = drain ? entData[head] : '0;
    assign cpu_rdata = rd ? (hit ? hitData : mem_rdata) : '0;
    always_ff @(posedge InputClk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                entAddr[tail] <= cpu_addr;
                entData[tail] <= cpu_wdata;
                tail <= tail + PW'(1);
            end
            if (coalesce) entData[youngest] <= cpu_wdata;
            if (drain) head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(drain);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenario tests for store_buffer with hand-computed expectations
module tb_store_buffer;
    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] RD = 3'b010;
    localparam logic [2:0] WR = 3'b100;
    localparam logic [31:0] MEMRD = 32'hDEADBEEF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [2:0] cpu_ctrl = '0;
    logic [31:0] cpu_rdata;
    logic stall, sb_empty, mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = MEMRD;
    logic mem_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_buffer dut (
        .InputClk(clk),
        .rst(rst),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ctrl(cpu_ctrl),
        .cpu_rdata(cpu_rdata),
        .stall(stall),
        .sb_empty(sb_empty),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en),
        .mem_ready(mem_ready)
    );

    // inputs change on the falling edge; outputs are looked at 1ns later
    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        cpu_ctrl = c;
        cpu_addr = a;
        cpu_wdata = d;
        mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(IDLE, 32'h0, 32'h0, 1'b0);
        drive(IDLE, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        drive(IDLE, 32'h0, 32'h0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", sb_empty); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", mem_read_en); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", mem_write_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mwdata got %h want 0", mem_wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    endtask

    task automatic test_single_drain;
        drive(WR, 32'h10, 32'hAAAA5555, 1'b1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL single_stall got %b want 0", stall); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL single_samecycle_wren got %b want 0", mem_write_en); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL single_wren got %b want 1", mem_write_en); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL single_addr got %h want 10", mem_addr); end
        checks++; if (mem_wdata !== 32'hAAAA5555) begin errors++; $display("FAIL single_data got %h want aaaa5555", mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", sb_empty); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL single_after_wren got %b want 0", mem_write_en); end
    endtask

    task automatic test_full_stall;
        logic [31:0] expA [5] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40};
        logic [31:0] expD [5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h4040};
        for (int i = 0; i < 4; i++) begin
            drive(WR, expA[i], expD[i], 1'b0);
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got %b want 0", i, stall); end
        end
        drive(WR, 32'h40, 32'h4040, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", stall); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL full_noready_wren got %b want 0", mem_write_en); end
        drive(WR, 32'h40, 32'h4040, 1'b1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_nobypass_stall got %b want 1", stall); end
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== expA[0] || mem_wdata !== expD[0])
            begin errors++; $display("FAIL full_drain_0 got en=%b %h/%h want 1 %h/%h", mem_write_en, mem_addr, mem_wdata, expA[0], expD[0]); end
        drive(WR, 32'h40, 32'h4040, 1'b1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_release_stall got %b want 0", stall); end
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== expA[1] || mem_wdata !== expD[1])
            begin errors++; $display("FAIL full_drain_1 got en=%b %h/%h want 1 %h/%h", mem_write_en, mem_addr, mem_wdata, expA[1], expD[1]); end
        for (int i = 2; i < 5; i++) begin
            drive(IDLE, 32'h0, 32'h0, 1'b1);
            checks++; if (mem_write_en !== 1'b1 || mem_addr !== expA[i] || mem_wdata !== expD[i])
                begin errors++; $display("FAIL full_drain_%0d got en=%b %h/%h want 1 %h/%h", i, mem_write_en, mem_addr, mem_wdata, expA[i], expD[i]); end
        end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b want 1", sb_empty); end
    endtask

    task automatic test_forward;
        drive(WR, 32'h20, 32'd1, 1'b0);
        drive(WR, 32'h24, 32'd2, 1'b0);
        drive(WR, 32'h20, 32'd3, 1'b0);
        drive(RD, 32'h20, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== 32'd3) begin errors++; $display("FAIL fwd_hit_data got %h want 3", cpu_rdata); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL fwd_hit_rden got %b want 0", mem_read_en); end
        drive(RD, 32'h24, 32'h0, 1'b0);
        checks++; if (cpu_rdata !== 32'd2) begin errors++; $display("FAIL fwd_hit24_data got %h want 2", cpu_rdata); end
        drive(RD, 32'h28, 32'h0, 1'b0);
        checks++; if (mem_read_en !== 1'b1) begin errors++; $display("FAIL fwd_miss_rden got %b want 1", mem_read_en); end
        checks++; if (mem_addr !== 32'h28) begin errors++; $display("FAIL fwd_miss_addr got %h want 28", mem_addr); end
        checks++; if (cpu_rdata !== MEMRD) begin errors++; $display("FAIL fwd_miss_data got %h want %h", cpu_rdata, MEMRD); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'd1)
            begin errors++; $display("FAIL fwd_drain_0 got en=%b %h/%h want 1 20/1", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'd2)
            begin errors++; $display("FAIL fwd_drain_1 got en=%b %h/%h want 1 24/2", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'd3)
            begin errors++; $display("FAIL fwd_drain_2 got en=%b %h/%h want 1 20/3", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %b want 1", sb_empty); end
    endtask

    task automatic test_coalesce;
        drive(WR, 32'h30, 32'd5, 1'b0);
        drive(WR, 32'h30, 32'd6, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL coal_stall got %b want 0", stall); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h30 || mem_wdata !== 32'd6)
            begin errors++; $display("FAIL coal_drain got en=%b %h/%h want 1 30/6", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b0 || sb_empty !== 1'b1)
            begin errors++; $display("FAIL coal_single got en=%b empty=%b want 0 1", mem_write_en, sb_empty); end
    endtask

    task automatic test_coalesce_retiring;
        drive(WR, 32'h60, 32'd7, 1'b1);
        drive(WR, 32'h60, 32'd8, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h60 || mem_wdata !== 32'd7)
            begin errors++; $display("FAIL retire_old got en=%b %h/%h want 1 60/7", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h60 || mem_wdata !== 32'd8)
            begin errors++; $display("FAIL retire_new got en=%b %h/%h want 1 60/8", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL retire_empty got %b want 1", sb_empty); end
    endtask

    task automatic test_port_conflict;
        drive(WR, 32'h70, 32'h11, 1'b0);
        drive(WR, 32'h74, 32'h22, 1'b0);
        drive(RD, 32'h78, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL conflict_wren got %b want 0", mem_write_en); end
        checks++; if (mem_read_en !== 1'b1 || mem_addr !== 32'h78)
            begin errors++; $display("FAIL conflict_read got en=%b %h want 1 78", mem_read_en, mem_addr); end
        drive(RD, 32'h70, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h70 || mem_wdata !== 32'h11)
            begin errors++; $display("FAIL conflict_resume got en=%b %h/%h want 1 70/11", mem_write_en, mem_addr, mem_wdata); end
        checks++; if (cpu_rdata !== 32'h11) begin errors++; $display("FAIL conflict_fwd got %h want 11", cpu_rdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h74 || mem_wdata !== 32'h22)
            begin errors++; $display("FAIL conflict_drain got en=%b %h/%h want 1 74/22", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL conflict_empty got %b want 1", sb_empty); end
    endtask

    task automatic test_both_bits;
        drive(3'b110, 32'h80, 32'h99, 1'b0);
        checks++; if (cpu_rdata !== 32'h0 || mem_read_en !== 1'b0)
            begin errors++; $display("FAIL both_read got %h en=%b want 0 0", cpu_rdata, mem_read_en); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
        checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h99)
            begin errors++; $display("FAIL both_write got en=%b %h/%h want 1 80/99", mem_write_en, mem_addr, mem_wdata); end
        drive(IDLE, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid;
        drive(WR, 32'h90, 32'h1, 1'b0);
        drive(WR, 32'h94, 32'h2, 1'b0);
        drive(WR, 32'h98, 32'h3, 1'b0);
        drive(IDLE, 32'h0, 32'h0, 1'b0);
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL mid_pending got %b want 0", sb_empty); end
        rst = 1'b1;
        drive(IDLE, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", sb_empty); end
        for (int i = 0; i < 3; i++) begin
            drive(IDLE, 32'h0, 32'h0, 1'b1);
            checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL mid_wren_%0d got %b want 0", i, mem_write_en); end
        end
    endtask

    initial begin
        test_reset;
        test_single_drain;
        test_full_stall;
        test_forward;
        test_coalesce;
        test_coalesce_retiring;
        test_port_conflict;
        test_both_bits;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write store buffer between SC_CPU's data bus and the DataMemory port.
- Absorbs CPU stores into a small in-order FIFO and drains them to memory when the memory port is free.
- Forwards buffered data to CPU loads, so a load never returns stale data.
- Raises stall when full, so the CPU holds the bus until an entry frees.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width (word-granular stores; no byte enables)
- DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
- InputClk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU address bus
- cpu_wdata  in  DATA_W  CPU store data
- cpu_ctrl  in  3  CPU control bus: [1]=read, [2]=write, [0] ignored
- cpu_rdata  out  DATA_W  load data to the CPU (combinational)
- stall  out  1  store not accepted this cycle; CPU must hold the bus
- sb_empty  out  1  no pending stores (used by the bench before end-of-run checks)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational from memory)
- mem_read_en  out  1  memory read strobe
- mem_write_en  out  1  memory write strobe; the write commits at the rising edge
- mem_ready  in  1  memory accepts a write this cycle; tied 1 for the single-port DataMemory

Behaviour:
- State:
  - entry array {addr, data}[DEPTH]
  - head and tail pointers, log2(DEPTH) bits, wrap modulo DEPTH
  - count, log2(DEPTH)+1 bits
- Reset (rst=1 at an edge):
  - head, tail and count become 0; pending stores are discarded.
  - Outputs after reset: stall=0, sb_empty=1, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
  - Reset has priority over every simultaneous enqueue or drain.
- Command decode:
  - wr = cpu_ctrl[2]; rd = cpu_ctrl[1] & ~cpu_ctrl[2].
  - cpu_ctrl with both bits set is treated as a write; the read is ignored and cpu_rdata=0.
- Store (wr=1):
  - Coalesce: if count>0 and cpu_addr equals the youngest entry's addr (tail-1), overwrite that entry's data. count and tail are unchanged, and this is never stalled.
  - Else, if count<DEPTH: write {cpu_addr, cpu_wdata} at tail, tail+1, stall=0.
  - Else (full): stall=1 combinationally and nothing is written. There is no same-cycle bypass of drain into enqueue.
- Load (rd=1):
  - Compare cpu_addr against all valid entries; the youngest match wins.
  - Hit: cpu_rdata = entry data; mem_read_en=0.
  - Miss: mem_read_en=1, mem_addr=cpu_addr, cpu_rdata=mem_rdata.
  - Loads are never stalled.
- Drain (memory port free = not a load miss):
  - Condition: count>0, mem_ready=1 and the port is free.
  - Then mem_write_en=1, mem_addr/mem_wdata = head entry, and head+1 at the edge.
  - Otherwise mem_write_en=0, with mem_addr/mem_wdata driven to 0 when no read is active.
- Simultaneous events:
  - Enqueue plus drain: count unchanged.
  - Coalesce into an entry that is also head and draining this cycle: the drain writes the old data. The entry retires, so the coalesce must instead enqueue as a new entry; coalescing is disabled when count==1 and a drain fires.
- Ordering and latency:
  - Memory writes occur in strict program order.
  - An accepted store reaches memory no earlier than the next cycle: minimum store-to-mem_write_en latency is 1 cycle.
- Status: sb_empty = (count==0); stall is purely a function of the current state and the current wr/address.

Decomposition:
- Shared package sb_pkg:
  - CTRL_RD=1, CTRL_WR=2 bit indices
  - sb_entry_t {addr, data}
  - function clog2-based pointer widths
- One natural sub-module, sb_match: DEPTH-way address compare plus youngest-first priority select. Inputs: entries, valid mask, tail. Outputs: hit, data.

Test Plan:
1. Single store drain: mem_ready=1, store 0x10<-0xAAAA5555 → next cycle mem_write_en=1, mem_addr=0x10, mem_wdata=0xAAAA5555; cycle after, sb_empty=1.
2. Full and stall: mem_ready=0, stores to 0x00/0x04/0x08/0x0C → count=4. A 5th store to 0x40 gives stall=1. Raise mem_ready: one entry drains per cycle in order 0x00..0x0C; stall drops after the first drain and 0x40 enqueues.
3. Forwarding: mem_ready=0, stores 0x20<-1, 0x24<-2, 0x20<-3, then load 0x20 → cpu_rdata=3, mem_read_en=0. Load 0x28 → mem_read_en=1, cpu_rdata=mem_rdata.
4. Coalescing: mem_ready=0, stores 0x30<-5 then 0x30<-6 → count=1. On drain, exactly one write of 0x30<-6.
5. Port conflict: 2 pending, mem_ready=1, load miss → no mem_write_en that cycle. Drain resumes the next non-miss cycle.
6. Reset mid-operation: 3 pending, mem_ready=0, pulse rst one cycle → count=0, sb_empty=1, no mem_write_en after mem_ready rises.
